// File: rtl/cacheline_adaptor_pkg.sv
// -----------------------------------------------------------------------------
// adaptor_types
//
// Shared definitions for the cache-line / memory-burst adaptor:
//   - default line and beat widths
//   - beats per line and the number of byte-offset bits inside one line
//   - the adaptor state encoding (2 bits)
// -----------------------------------------------------------------------------
package adaptor_types;

    localparam int unsigned DEFAULT_LINE_WIDTH  = 256;
    localparam int unsigned DEFAULT_BURST_WIDTH = 64;
    localparam int unsigned DEFAULT_ADDR_WIDTH  = 32;

    // Beats needed to move one line, and byte-offset bits cleared on address_o.
    localparam int unsigned BEATS       = DEFAULT_LINE_WIDTH / DEFAULT_BURST_WIDTH;
    localparam int unsigned OFFSET_BITS = $clog2(DEFAULT_LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2,
        DONE     = 2'd3
    } adaptor_state_e;

endpackage : adaptor_types

// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//
// Bridges the cache controller's line port and a burst main-memory interface.
// A line read becomes BEATS incoming beats assembled into line_o; a line write
// becomes BEATS outgoing beats on burst_o. One request in flight; the cache
// holds read_i/write_i until the one-cycle resp_o pulse.
//
// Optional feature (compile-time macro ADAPTOR_TIMEOUT_EN):
//   adds parameter TIMEOUT_CYCLES and output timeout_o, a sticky flag raised
//   when a burst sees TIMEOUT_CYCLES consecutive cycles without resp_i.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   line_i     in   write line from the cache
//   line_o     out  assembled read line (registered)
//   address_i  in   line address from the cache
//   read_i     in   line read request, held until resp_o
//   write_i    in   line write request, held until resp_o (wins over read_i)
//   resp_o     out  one-cycle completion pulse
//   burst_i    in   read beat from memory
//   burst_o    out  write beat to memory
//   address_o  out  line-aligned memory address
//   read_o     out  memory burst read request
//   write_o    out  memory burst write request
//   resp_i     in   memory beat strobe, one per beat
//   timeout_o  out  sticky watchdog flag (ADAPTOR_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module cacheline_adaptor
    import adaptor_types::*;
#(
    parameter int unsigned LINE_WIDTH  = DEFAULT_LINE_WIDTH,
    parameter int unsigned BURST_WIDTH = DEFAULT_BURST_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
`ifdef ADAPTOR_TIMEOUT_EN
    ,parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,

    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
`ifdef ADAPTOR_TIMEOUT_EN
    ,output logic                  timeout_o
`endif
);

    localparam int unsigned NUM_BEATS   = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned ADDR_OFFSET = $clog2(LINE_WIDTH / 8);
    localparam int unsigned CNT_W       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    adaptor_state_e          state_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;
    logic [LINE_WIDTH-1:0]   wline_q;   // write line captured at accept
    logic [LINE_WIDTH-1:0]   rline_q;   // read line being assembled / held
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [BURST_WIDTH-1:0]  burst_q;
    logic                    read_q;
    logic                    write_q;
    logic                    resp_q;
    logic [ADDR_WIDTH-1:0]   aligned_addr;

    // Beat counter advance; wraps to 0 after the last beat on its own.
    assign count_d = count_q + 1'b1;

    assign aligned_addr = {address_i[ADDR_WIDTH-1:ADDR_OFFSET], {ADDR_OFFSET{1'b0}}};

    // NOTE: every state register is assigned with <= so all of them sample the
    // values from before the edge, independent of statement order.
    // NOTE: the line registers are reset along with the FSM: line_o is visible
    // to the cache directly and must read as 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            wline_q <= '0;
            rline_q <= '0;
            addr_q  <= '0;
            burst_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // resp_i is deliberately ignored here.
                    if (write_i) begin
                        wline_q <= line_i;
                        addr_q  <= aligned_addr;
                        burst_q <= line_i[BURST_WIDTH-1:0];
                        count_q <= '0;
                        write_q <= 1'b1;
                        state_q <= WR_BURST;
                    end else if (read_i) begin
                        addr_q  <= aligned_addr;
                        count_q <= '0;
                        read_q  <= 1'b1;
                        state_q <= RD_BURST;
                    end
                end

                WR_BURST: begin
                    // Gap cycles (resp_i low) leave burst_o untouched.
                    if (resp_i) begin
                        count_q <= count_d;
                        if (count_q == LAST_BEAT) begin
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            burst_q <= wline_q[count_d*BURST_WIDTH +: BURST_WIDTH];
                        end
                    end
                end

                RD_BURST: begin
                    if (resp_i) begin
                        rline_q[count_q*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                        count_q <= count_d;
                        if (count_q == LAST_BEAT) begin
                            read_q  <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end

                DONE: begin
                    // Requests still high here are the ones just completed;
                    // they are not accepted again until IDLE.
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign line_o    = rline_q;
    assign burst_o   = burst_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;

`ifdef ADAPTOR_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q;
    logic            in_burst;

    assign in_burst = (state_q == WR_BURST) || (state_q == RD_BURST);

    // Counts idle cycles inside a burst; saturates at the limit so the flag
    // is raised exactly once and the counter never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == IDLE && (write_i || read_i)) begin
                to_cnt_q <= '0;
            end else if (in_burst) begin
                if (resp_i) begin
                    to_cnt_q <= '0;
                end else if (to_cnt_q != TO_LIMIT) begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    if (to_cnt_q == TO_LIMIT - 1'b1) begin
                        timeout_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign timeout_o = timeout_q;
`endif

endmodule : cacheline_adaptor

// File: tb/tb_cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adaptor
//
// Self-checking bench for cacheline_adaptor. A transaction-level model tracks
// the expected read line and, for each line transfer, derives the expected
// memory-side outputs from the beat index. Inputs change and outputs are
// sampled on the falling clock edge. Build with +define+ADAPTOR_TIMEOUT_EN to
// include the watchdog scenario (TIMEOUT_CYCLES=16).
// -----------------------------------------------------------------------------
module tb_cacheline_adaptor;
    import adaptor_types::*;

    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] line_i;
    logic [LW-1:0] line_o;
    logic [AW-1:0] address_i;
    logic          read_i;
    logic          write_i;
    logic          resp_o;
    logic [BW-1:0] burst_i;
    logic [BW-1:0] burst_o;
    logic [AW-1:0] address_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i;
`ifdef ADAPTOR_TIMEOUT_EN
    logic          timeout_o;
`endif

    cacheline_adaptor #(
        .LINE_WIDTH (LW),
        .BURST_WIDTH(BW),
        .ADDR_WIDTH (AW)
`ifdef ADAPTOR_TIMEOUT_EN
        ,.TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .line_i   (line_i),
        .line_o   (line_o),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .resp_o   (resp_o),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .resp_i   (resp_i)
`ifdef ADAPTOR_TIMEOUT_EN
        ,.timeout_o(timeout_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model of the line the cache should see on line_o.
    logic [LW-1:0] exp_line;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] line_align(input logic [AW-1:0] a);
        return (a >> OFFSET_BITS) << OFFSET_BITS;
    endfunction

    // One complete line transfer. Write wins when both requests are high.
    // Each beat is preceded by a random number of idle cycles in [gap_lo, gap_hi].
    task automatic run_txn(input bit wr, input bit rd, input logic [AW-1:0] addr,
                           input logic [LW-1:0] data, input int gap_lo, input int gap_hi);
        bit            is_wr;
        logic [AW-1:0] exp_addr;
        is_wr    = wr;
        exp_addr = line_align(addr);
        write_i   = wr;
        read_i    = rd;
        address_i = addr;
        line_i    = wr ? data : rand_line();
        @(negedge clk);
        // Accepted on the previous edge; the cache-side inputs are scrambled to
        // show that the adaptor works from its captured copies.
        line_i    = rand_line();
        address_i = $urandom;
        for (int k = 0; k < BEATS; k++) begin
            int gap;
            gap = $urandom_range(gap_hi, gap_lo);
            for (int g = 0; g <= gap; g++) begin
                check("busy_write_o", write_o, is_wr);
                check("busy_read_o", read_o, !is_wr);
                check("busy_resp_o", resp_o, 0);
                check("address_o", address_o, exp_addr);
                check("line_o_busy", line_o, exp_line);
                if (is_wr) check("burst_o", burst_o, data[k*BW +: BW]);
                resp_i  = (g == gap);
                burst_i = (g == gap && !is_wr) ? data[k*BW +: BW] : {$urandom, $urandom};
                @(negedge clk);
                if (g == gap && !is_wr) exp_line[k*BW +: BW] = data[k*BW +: BW];
            end
        end
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        check("resp_pulse", resp_o, 1);
        check("done_read_o", read_o, 0);
        check("done_write_o", write_o, 0);
        check("line_o_done", line_o, exp_line);
        write_i = 1'b0;
        read_i  = 1'b0;
        @(negedge clk);
        check("resp_single", resp_o, 0);
        check("idle_read_o", read_o, 0);
        check("idle_write_o", write_o, 0);
    endtask

    initial begin
        logic [LW-1:0] d;
        rst       = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        exp_line  = '0;

        // Reset values.
        #2;
        check("rst_resp_o", resp_o, 0);
        check("rst_read_o", read_o, 0);
        check("rst_write_o", write_o, 0);
        check("rst_burst_o", burst_o, 0);
        check("rst_address_o", address_o, 0);
        check("rst_line_o", line_o, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Read with consecutive beats at an unaligned address.
        d = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        run_txn(0, 1, 32'h0000_1234, d, 0, 0);
        check("read_line_value", line_o, d);

        // Write with 3-cycle gaps, followed back-to-back by a fetch.
        d = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        run_txn(1, 0, 32'h0000_2040, d, 3, 3);
        run_txn(0, 1, 32'h0000_3000, rand_line(), 0, 1);

        // Both requests high: write burst only.
        run_txn(1, 1, 32'hABCD_EF1F, rand_line(), 0, 2);

        // Reset after beat 2 of a read.
        d = rand_line();
        read_i    = 1'b1;
        address_i = 32'h0000_5000;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            resp_i  = 1'b1;
            burst_i = d[k*BW +: BW];
            @(negedge clk);
        end
        resp_i = 1'b0;
        rst    = 1'b0;
        #1;
        exp_line = '0;
        check("midrst_read_o", read_o, 0);
        check("midrst_resp_o", resp_o, 0);
        check("midrst_line_o", line_o, 0);
        check("midrst_address_o", address_o, 0);
        read_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("postrst_read_o", read_o, 0);
            check("postrst_resp_o", resp_o, 0);
        end

        // Stray beat strobe while idle.
        resp_i  = 1'b1;
        burst_i = {$urandom, $urandom};
        @(negedge clk);
        resp_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("idle_strobe_read_o", read_o, 0);
            check("idle_strobe_write_o", write_o, 0);
            check("idle_strobe_resp_o", resp_o, 0);
            check("idle_strobe_line_o", line_o, exp_line);
            @(negedge clk);
        end

        // Fresh read after reset.
        run_txn(0, 1, 32'h0000_5000, rand_line(), 0, 2);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            int kind;
            kind = $urandom_range(2, 0);
            run_txn(kind != 1, kind != 0, $urandom, rand_line(), 0, $urandom_range(3, 0));
        end

`ifdef ADAPTOR_TIMEOUT_EN
        check("timeout_clear", timeout_o, 0);
        d = rand_line();
        read_i    = 1'b1;
        address_i = 32'h0000_7000;
        @(negedge clk);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            check("timeout_count", timeout_o, (n >= 16));
        end
        for (int k = 0; k < BEATS; k++) begin
            resp_i  = 1'b1;
            burst_i = d[k*BW +: BW];
            @(negedge clk);
            check("timeout_sticky", timeout_o, 1);
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        check("timeout_resp", resp_o, 1);
        check("timeout_line", line_o, d);
        @(negedge clk);
        check("timeout_hold", timeout_o, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cacheline_adaptor
